sha_msg_padder: RTL and testbench
=================================

// Module: sha_msg_padder
// PURPOSE
//  Streaming SHA-2 message padder. Accepts message bytes over a valid/ready handshake and buffers one block.
//  Appends 0x80, zero fill and the big-endian bit-length field. Emits complete blocks as big-endian words to the compression core.
//  Generalises the single-block SHA-256 padder: multi-block messages, SHA-256/SHA-512 geometry, output backpressure.
// PARAMETERS
//  WORD_W        32   output word width; 32 (SHA-256) or 64 (SHA-512)
//  BLOCK_BYTES   64   block size in bytes; 64 or 128, paired with WORD_W
//  LEN_BYTES     8    length-field bytes; 8 or 16
//  CNT_W         32   message byte-counter width
//  MAX_MSG_BYTES 2**CNT_W-1  byte limit; used only with PAD_LEN_CHK_EN
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous reset, active-low
//  in_valid       in   1       in_data holds a message byte
//  in_ready       out  1       padder accepts a byte this cycle
//  in_data        in   8       message byte, in message order
//  in_last        in   1       qualifies the final byte of the message
//  out_valid      out  1       out_data holds a block word
//  out_ready      in   1       consumer accepts the word
//  out_data       out  WORD_W  block word; first byte in the MSBs
//  out_last_word  out  1       word is the last word of its block
//  out_last_block out  1       word belongs to the final (length-bearing) block
//  len_err        out  1       length overflow flag; port exists only with PAD_LEN_CHK_EN
// BEHAVIOUR
//  Reset: all outputs 0; state FILL; byte pointer 0; byte count 0; buffer contents don't-care.
//  Transfers: a transfer occurs when valid && ready, on both sides.
//  States:
//   FILL: in_ready=1. Each accepted byte goes to buf[ptr]; ptr++; cnt++.
//     Block full, not last -> EMIT, then return FILL.
//     Block full and last -> EMIT, then return PAD80.
//     Last byte, block not full -> PAD80.
//   PAD80: writes 0x80 to buf[ptr]; ptr++. Takes one cycle.
//     Block now full -> EMIT, then return ZERO.
//     Otherwise -> ZERO.
//   ZERO: writes 0x00 at one byte per cycle until ptr == BLOCK_BYTES-LEN_BYTES, then -> LEN.
//     If ptr was already past that point, fills to the end of the block, -> EMIT, returns ZERO at ptr 0.
//   LEN: writes {cnt,3'b000}, zero-extended to LEN_BYTES*8 bits, MSB byte first. Takes LEN_BYTES cycles.
//     Then -> EMIT with final=1.
//   EMIT: out_valid=1. out_data = word[rd], rd from 0 to BLOCK_BYTES*8/WORD_W-1.
//     rd advances only on a transfer. out_data and flags stay stable while stalled.
//     After the last word transfers: ptr=0. Final block -> FILL with cnt=0. Otherwise -> saved return state.
//  Handshake rules: in_ready=0 in every state except FILL. out_valid=0 outside EMIT. No combinational path from out_ready to in_ready.
//  Latency example, SHA-256, 3-byte message: 3 FILL + 1 PAD80 + 52 ZERO + 8 LEN cycles, then 16 words at out_ready=1.
//  Zero-length messages are not supported; every message has at least one byte carrying in_last.
//  rst asserted in any state aborts the message and returns to reset values. No partial block is emitted.
// CONFIGURATION
//  PAD_LEN_CHK_EN defined:
//   A byte offered when cnt == MAX_MSG_BYTES is consumed and discarded; len_err is set (sticky).
//   If that byte carries in_last, padding proceeds normally.
//   len_err clears on reset or when the final block's last word transfers.
//  PAD_LEN_CHK_EN undefined: no len_err port; cnt wraps modulo 2**CNT_W.
// STRUCTURE
//  Package sha_pad_pkg holds:
//   state enum (FILL, PAD80, ZERO, LEN, EMIT);
//   SHA256/SHA512 geometry constants (BLOCK_BYTES, LEN_BYTES, WORD_W);
//   derived WORDS_PER_BLOCK and PTR_W.
//  Sub-module sha_pad_block_buf: BLOCK_BYTES-byte buffer, one byte-write port, one WORD_W-wide big-endian read port.
//  The FSM, counters and return-state register stay in sha_msg_padder.
// TESTING (SHA-256 defaults unless noted)
//  1. "abc" (61 62 63, last on 63) -> one block:
//     w0=0x61626380, w1..w14=0, w15=0x00000018; out_last_block=1 on all 16 words.
//  2. 56 bytes of 0x00 -> block 1: w14=0x80000000, w15=0, out_last_block=0.
//     Block 2: w0..w14=0, w15=0x000001C0, out_last_block=1.
//  3. 64 bytes, last on byte 63 -> block 1 holds the data only.
//     Block 2: w0=0x80000000, w15=0x00000200.
//  4. Toggle out_ready randomly during EMIT -> words unchanged while stalled; none lost or duplicated; in_ready stays 0.
//  5. Assert rst mid-EMIT, then send "abc" -> output identical to test 1.
//  6. WORD_W=64, BLOCK_BYTES=128, LEN_BYTES=16, "abc" -> w0=0x6162638000000000, w15=0x18.
//     With PAD_LEN_CHK_EN, MAX_MSG_BYTES=4 and a 5-byte message -> len_err=1, length field = 0x20.

Source files
------------

// File: rtl/sha_pad_pkg.sv
// Shared definitions for the streaming SHA-2 message padder: FSM states,
// SHA-256/SHA-512 block geometry and helpers for derived widths.
package sha_pad_pkg;

    typedef enum logic [2:0] {
        FILL,
        PAD80,
        ZERO,
        LEN,
        EMIT
    } pad_state_t;

    localparam int SHA256_WORD_W      = 32;
    localparam int SHA256_BLOCK_BYTES = 64;
    localparam int SHA256_LEN_BYTES   = 8;

    localparam int SHA512_WORD_W      = 64;
    localparam int SHA512_BLOCK_BYTES = 128;
    localparam int SHA512_LEN_BYTES   = 16;

    function automatic int words_per_block(input int block_bytes, input int word_w);
        return (block_bytes * 8) / word_w;
    endfunction

    function automatic int ptr_w(input int block_bytes);
        return $clog2(block_bytes);
    endfunction

    localparam int SHA256_WORDS_PER_BLOCK = words_per_block(SHA256_BLOCK_BYTES, SHA256_WORD_W);
    localparam int SHA256_PTR_W           = ptr_w(SHA256_BLOCK_BYTES);
    localparam int SHA512_WORDS_PER_BLOCK = words_per_block(SHA512_BLOCK_BYTES, SHA512_WORD_W);
    localparam int SHA512_PTR_W           = ptr_w(SHA512_BLOCK_BYTES);

endpackage

// File: rtl/sha_pad_block_buf.sv
// One-block byte buffer for the SHA-2 padder: a single byte-write port and a
// word-wide read port that returns bytes big-endian (lowest address in the MSBs).
module sha_pad_block_buf
    import sha_pad_pkg::*;
#(
    parameter int BLOCK_BYTES = SHA256_BLOCK_BYTES,
    parameter int WORD_W      = SHA256_WORD_W,
    localparam int PTR_W      = ptr_w(BLOCK_BYTES),
    localparam int RD_W       = $clog2(words_per_block(BLOCK_BYTES, WORD_W))
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [RD_W-1:0]   rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    localparam int BYTES_PER_WORD = WORD_W / 8;

    logic [7:0] mem [BLOCK_BYTES];

    // NOTE: the storage has no reset; every byte is rewritten before a block is read out.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: rd_data gets a default before the loop so no path can infer a latch.
    always_comb begin
        rd_data = '0;
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
            rd_data[WORD_W-1-8*b -: 8] = mem[PTR_W'(int'(rd_addr) * BYTES_PER_WORD + b)];
        end
    end

endmodule

// File: rtl/sha_msg_padder.sv
// Streaming SHA-2 message padder: buffers one block, appends 0x80, zero fill and
// the bit length, and emits big-endian words. Optional length check: PAD_LEN_CHK_EN.
module sha_msg_padder
    import sha_pad_pkg::*;
#(
    parameter int WORD_W      = SHA256_WORD_W,
    parameter int BLOCK_BYTES = SHA256_BLOCK_BYTES,
    parameter int LEN_BYTES   = SHA256_LEN_BYTES,
    parameter int CNT_W       = 32
`ifdef PAD_LEN_CHK_EN
    ,
    parameter logic [CNT_W-1:0] MAX_MSG_BYTES = {CNT_W{1'b1}}
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last_word,
    output logic              out_last_block
`ifdef PAD_LEN_CHK_EN
    ,
    output logic              len_err
`endif
);

    localparam int WPB       = words_per_block(BLOCK_BYTES, WORD_W);
    localparam int PTR_W     = ptr_w(BLOCK_BYTES);
    localparam int RD_W      = $clog2(WPB);
    localparam int LEN_W     = LEN_BYTES * 8;
    localparam int LEN_IDX_W = $clog2(LEN_BYTES);

    localparam logic [PTR_W-1:0] LEN_START = PTR_W'(BLOCK_BYTES - LEN_BYTES);
    localparam logic [PTR_W-1:0] LEN_PRE   = PTR_W'(BLOCK_BYTES - LEN_BYTES - 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BLOCK_BYTES - 1);
    localparam logic [RD_W-1:0]  LAST_RD   = RD_W'(WPB - 1);

    pad_state_t        state;
    pad_state_t        ret_state;
    logic [PTR_W-1:0]  ptr;
    logic [RD_W-1:0]   rd;
    logic [CNT_W-1:0]  cnt;
    logic              final_blk;

    logic              in_fire;
    logic              over_max;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic [LEN_W-1:0]  len_bits;
    logic [LEN_IDX_W-1:0] len_idx;
    logic [WORD_W-1:0] rd_word;

    assign in_fire = in_valid && in_ready;

`ifdef PAD_LEN_CHK_EN
    assign over_max = (cnt == MAX_MSG_BYTES);
`else
    assign over_max = 1'b0;
`endif

    // Length field is the bit count; the block tail is LEN_BYTES-aligned, so the low
    // pointer bits index the field from its MSB byte.
    assign len_bits = {{(LEN_W - CNT_W - 3){1'b0}}, cnt, 3'b000};
    assign len_idx  = ~ptr[LEN_IDX_W-1:0];

    always_comb begin
        wr_en   = 1'b0;
        wr_data = 8'h00;
        unique case (state)
            FILL: begin
                wr_en   = in_fire && !over_max;
                wr_data = in_data;
            end
            PAD80: begin
                wr_en   = 1'b1;
                wr_data = 8'h80;
            end
            ZERO: begin
                wr_en   = (ptr != LEN_START);
                wr_data = 8'h00;
            end
            LEN: begin
                wr_en   = 1'b1;
                wr_data = len_bits[{len_idx, 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    sha_pad_block_buf #(
        .BLOCK_BYTES (BLOCK_BYTES),
        .WORD_W      (WORD_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (ptr),
        .wr_data (wr_data),
        .rd_addr (rd),
        .rd_data (rd_word)
    );

    // NOTE: all state below is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FILL;
            ret_state <= FILL;
            ptr       <= '0;
            rd        <= '0;
            cnt       <= '0;
            final_blk <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
`ifdef PAD_LEN_CHK_EN
            len_err   <= 1'b0;
`endif
        end else begin
            unique case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (in_fire) begin
                        if (!over_max) begin
                            ptr <= ptr + PTR_W'(1);
                            cnt <= cnt + CNT_W'(1);
                        end
                        if (!over_max && ptr == LAST_PTR) begin
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= EMIT;
                            ret_state <= in_last ? PAD80 : FILL;
                        end else if (in_last) begin
                            in_ready <= 1'b0;
                            state    <= PAD80;
                        end
`ifdef PAD_LEN_CHK_EN
                        if (over_max) begin
                            len_err <= 1'b1;
                        end
`endif
                    end
                end
                PAD80: begin
                    ptr <= ptr + PTR_W'(1);
                    if (ptr == LAST_PTR) begin
                        out_valid <= 1'b1;
                        state     <= EMIT;
                        ret_state <= ZERO;
                    end else begin
                        state <= ZERO;
                    end
                end
                ZERO: begin
                    // Past the length slot the rest of this block is zeroed and a fresh block follows.
                    if (ptr == LEN_START) begin
                        state <= LEN;
                    end else begin
                        ptr <= ptr + PTR_W'(1);
                        if (ptr == LAST_PTR) begin
                            out_valid <= 1'b1;
                            state     <= EMIT;
                            ret_state <= ZERO;
                        end else if (ptr == LEN_PRE) begin
                            state <= LEN;
                        end
                    end
                end
                LEN: begin
                    ptr <= ptr + PTR_W'(1);
                    if (ptr == LAST_PTR) begin
                        out_valid <= 1'b1;
                        final_blk <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (rd == LAST_RD) begin
                            rd        <= '0;
                            ptr       <= '0;
                            out_valid <= 1'b0;
                            if (final_blk) begin
                                state     <= FILL;
                                cnt       <= '0;
                                final_blk <= 1'b0;
                                in_ready  <= 1'b1;
`ifdef PAD_LEN_CHK_EN
                                len_err   <= 1'b0;
`endif
                            end else begin
                                state    <= ret_state;
                                in_ready <= (ret_state == FILL);
                            end
                        end else begin
                            rd <= rd + RD_W'(1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign out_data       = out_valid ? rd_word : '0;
    assign out_last_word  = out_valid && (rd == LAST_RD);
    assign out_last_block = out_valid && final_blk;

endmodule

// File: tb/tb_sha_msg_padder.sv
// Bench for sha_msg_padder: SHA-256 and SHA-512 instances checked against directed
// vectors and a byte-level padding model. Length-limit checks need PAD_LEN_CHK_EN.
module tb_sha_msg_padder;

    typedef logic [7:0] byte_t;

    typedef struct {
        int          u;
        int          len;
        int          kind;
        int          widx;
        logic [63:0] wexp;
        logic        lb_exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid   [2];
    logic        in_ready   [2];
    logic [7:0]  in_data    [2];
    logic        in_last    [2];
    logic        out_valid  [2];
    logic        out_ready  [2];
    logic        out_last_word  [2];
    logic        out_last_block [2];
    logic        len_err    [2];
    logic [31:0] od0;
    logic [63:0] od1;

    int checks = 0;
    int errors = 0;

    logic [65:0] got_q [$];
    logic [65:0] exp_q [$];
    byte_t       msg_q [$];
    vec_t        vecs  [11];

    always #5 clk = ~clk;

    sha_msg_padder d256 (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid[0]),
        .in_ready       (in_ready[0]),
        .in_data        (in_data[0]),
        .in_last        (in_last[0]),
        .out_valid      (out_valid[0]),
        .out_ready      (out_ready[0]),
        .out_data       (od0),
        .out_last_word  (out_last_word[0]),
        .out_last_block (out_last_block[0])
`ifdef PAD_LEN_CHK_EN
        ,
        .len_err        (len_err[0])
`endif
    );

    sha_msg_padder #(
        .WORD_W      (64),
        .BLOCK_BYTES (128),
        .LEN_BYTES   (16),
        .CNT_W       (32)
`ifdef PAD_LEN_CHK_EN
        ,
        .MAX_MSG_BYTES (32'd4)
`endif
    ) d512 (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid[1]),
        .in_ready       (in_ready[1]),
        .in_data        (in_data[1]),
        .in_last        (in_last[1]),
        .out_valid      (out_valid[1]),
        .out_ready      (out_ready[1]),
        .out_data       (od1),
        .out_last_word  (out_last_word[1]),
        .out_last_block (out_last_block[1])
`ifdef PAD_LEN_CHK_EN
        ,
        .len_err        (len_err[1])
`endif
    );

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [65:0] cur(input int u);
        if (u == 0) return {out_last_word[0], out_last_block[0], 32'h0, od0};
        return {out_last_word[1], out_last_block[1], od1};
    endfunction

    function automatic int max_bytes(input int u);
`ifdef PAD_LEN_CHK_EN
        return (u == 1) ? 4 : 0;
`else
        return (u == 1) ? 0 : 0;
`endif
    endfunction

    // Reference: standard SHA-2 padding on the message bytes, then split into words.
    task automatic build_expected(input int u);
        int          bb, lb, bpw, n, nwords, nblk;
        byte_t       p [$];
        logic [127:0] bits;
        logic [63:0] data;
        bb  = (u == 0) ? 64 : 128;
        lb  = (u == 0) ? 8 : 16;
        bpw = (u == 0) ? 4 : 8;
        n   = msg_q.size();
        if (max_bytes(u) > 0 && n > max_bytes(u)) n = max_bytes(u);
        for (int i = 0; i < n; i++) p.push_back(msg_q[i]);
        p.push_back(8'h80);
        while ((p.size() % bb) != (bb - lb)) p.push_back(8'h00);
        bits = 128'(n) << 3;
        for (int i = lb - 1; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nwords = p.size() / bpw;
        nblk   = p.size() / bb;
        exp_q.delete();
        for (int w = 0; w < nwords; w++) begin
            data = '0;
            for (int b = 0; b < bpw; b++) data = {data[55:0], p[w*bpw + b]};
            exp_q.push_back({(w % 16) == 15, (w / 16) == nblk - 1, data});
        end
    endtask

    task automatic make_msg(input int kind, input int len);
        msg_q.delete();
        if (kind == 0) begin
            msg_q.push_back(8'h61);
            msg_q.push_back(8'h62);
            msg_q.push_back(8'h63);
        end else begin
            for (int i = 0; i < len; i++)
                msg_q.push_back(kind == 1 ? 8'h00 : kind == 2 ? 8'(i) : 8'($urandom_range(0, 255)));
        end
    endtask

    task automatic send(input int u, input bit gaps);
        int n;
        for (int i = 0; i < msg_q.size(); i++) begin
            if (gaps) begin
                in_valid[u] = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            in_valid[u] = 1'b1;
            in_data[u]  = msg_q[i];
            in_last[u]  = (i == msg_q.size() - 1);
            n = 0;
            while (!in_ready[u] && n < 3000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 3000) begin
                fail("send_timeout");
                break;
            end
            @(negedge clk);
        end
        in_valid[u] = 1'b0;
        in_last[u]  = 1'b0;
    endtask

    task automatic collect(input int u, input bit rnd);
        logic        pv = 1'b0;
        logic        pr = 1'b0;
        logic [65:0] pw = '0;
        bit          done = 1'b0;
        int          n = 0;
        got_q.delete();
        while (!done) begin
            @(negedge clk);
            if (pv && !pr) check("stall_hold", {out_valid[u], cur(u)}, {1'b1, pw});
            out_ready[u] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (out_valid[u]) begin
                check("in_ready_in_emit", in_ready[u], 0);
                if (out_ready[u]) begin
                    got_q.push_back(cur(u));
                    if (out_last_word[u] && out_last_block[u]) done = 1'b1;
                end
            end
            pv = out_valid[u];
            pr = out_ready[u];
            pw = cur(u);
            n++;
            if (!done && n > 20000) begin
                fail("collect_timeout");
                done = 1'b1;
            end
        end
        @(negedge clk);
        out_ready[u] = 1'b0;
    endtask

    task automatic compare_model(input int u, input string tag);
        build_expected(u);
        check({tag, "_nwords"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic run_msg(input int u, input bit rnd, input bit gaps, input string tag);
        @(negedge clk);
        fork
            send(u, gaps);
            collect(u, rnd);
        join
        compare_model(u, tag);
    endtask

    initial begin
        int n;
        for (int u = 0; u < 2; u++) begin
            in_valid[u]  = 1'b0;
            in_data[u]   = 8'h00;
            in_last[u]   = 1'b0;
            out_ready[u] = 1'b0;
        end
        vecs[0]  = '{0, 3,  0, 0,  64'h61626380, 1'b1};
        vecs[1]  = '{0, 3,  0, 7,  64'h0, 1'b1};
        vecs[2]  = '{0, 3,  0, 15, 64'h18, 1'b1};
        vecs[3]  = '{0, 56, 1, 14, 64'h80000000, 1'b0};
        vecs[4]  = '{0, 56, 1, 16, 64'h0, 1'b1};
        vecs[5]  = '{0, 56, 1, 31, 64'h1C0, 1'b1};
        vecs[6]  = '{0, 64, 2, 0,  64'h00010203, 1'b0};
        vecs[7]  = '{0, 64, 2, 16, 64'h80000000, 1'b1};
        vecs[8]  = '{0, 64, 2, 31, 64'h200, 1'b1};
        vecs[9]  = '{1, 3,  0, 0,  64'h6162638000000000, 1'b1};
        vecs[10] = '{1, 3,  0, 15, 64'h18, 1'b1};

        rst = 1'b1;
        #3 rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("reset_in_ready", in_ready[u], 0);
            check("reset_out_valid", out_valid[u], 0);
            check("reset_out", cur(u), 0);
        end
        rst = 1'b1;

        // Directed vectors: known words from hand-padded messages.
        foreach (vecs[i]) begin
            make_msg(vecs[i].kind, vecs[i].len);
            run_msg(vecs[i].u, 1'b0, 1'b0, $sformatf("vec%0d", i));
            if (vecs[i].widx < got_q.size()) begin
                check($sformatf("vec%0d_word", i), got_q[vecs[i].widx][63:0], vecs[i].wexp);
                check($sformatf("vec%0d_last_block", i), got_q[vecs[i].widx][64], vecs[i].lb_exp);
            end else begin
                fail($sformatf("vec%0d_missing_word", i));
            end
        end

        // Reset while a block is waiting on the consumer, then the same message again.
        make_msg(0, 3);
        @(negedge clk);
        send(0, 1'b0);
        n = 0;
        while (!out_valid[0] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail("emit_wait_timeout");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset_in_ready", in_ready[0], 0);
        check("midreset_out_valid", out_valid[0], 0);
        check("midreset_out", cur(0), 0);
        @(negedge clk);
        rst = 1'b1;
        run_msg(0, 1'b1, 1'b0, "after_reset");
        if (got_q.size() > 0) check("after_reset_w0", got_q[0][63:0], 64'h61626380);

`ifdef PAD_LEN_CHK_EN
        // SHA-512 instance is limited to 4 bytes: the fifth byte is dropped.
        make_msg(2, 5);
        @(negedge clk);
        send(1, 1'b0);
        n = 0;
        while (!out_valid[1] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail("len_err_wait_timeout");
        check("len_err_set", len_err[1], 1);
        collect(1, 1'b1);
        compare_model(1, "len_limit");
        if (got_q.size() == 16) check("len_limit_field", got_q[15][63:0], 64'h20);
        check("len_err_cleared", len_err[1], 0);
`endif

        // Block-boundary lengths, then random lengths, with random backpressure and gaps.
        for (int r = 0; r < 30; r++) begin
            int u;
            int len;
            int edge_len [10] = '{55, 56, 57, 63, 64, 65, 111, 112, 127, 128};
            if (r < 10) begin
                len = edge_len[r];
                u   = (r < 6) ? 0 : 1;
            end else begin
                len = $urandom_range(1, 300);
                u   = $urandom_range(0, 1);
            end
            make_msg(3, len);
            run_msg(u, 1'b1, 1'b1, $sformatf("rand%0d_len%0d", r, len));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
